// File: rtl/max7219_rx_decoder.sv
// max7219_rx_decoder: MAX7219 serial responder decoding 16-bit frames into digit/control registers.
// Define MAX7219_RX_DAISY_EN to add the max7219_rx_dout_Out chaining output.
module max7219_rx_decoder #(
    parameter int FRAME_BITS   = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int BITCNT_WIDTH = 5
) (
    input  logic       max7219_rx_CLOCK_50,
    input  logic       max7219_rx_RESET_InLow,
    input  logic       max7219_rx_din_In,
    input  logic       max7219_rx_clk_In,
    input  logic       max7219_rx_ncs_In,
    input  logic [2:0] max7219_rx_rdAddr_InBUS,
    output logic [7:0] max7219_rx_rdData_OutBUS,
    output logic [3:0] max7219_rx_intensity_OutBUS,
    output logic [2:0] max7219_rx_scanLimit_OutBUS,
    output logic [7:0] max7219_rx_decode_OutBUS,
    output logic       max7219_rx_shutdownN_Out,
    output logic       max7219_rx_test_Out,
    output logic       max7219_rx_frameValid_Out,
    output logic [3:0] max7219_rx_frameAddr_OutBUS,
`ifdef MAX7219_RX_DAISY_EN
    output logic       max7219_rx_dout_Out,
`endif
    output logic       max7219_rx_frameErr_Out
);

    // Without daisy chaining only the addr/data bits of the frame need to be kept.
`ifdef MAX7219_RX_DAISY_EN
    localparam int SR_BITS = FRAME_BITS;
`else
    localparam int SR_BITS = 12;
`endif

    logic [SYNC_STAGES-1:0]  dinSync, clkSync, ncsSync;
    logic                    clkPrev, ncsPrev, armed;
    logic [SR_BITS-1:0]      sr;
    logic [BITCNT_WIDTH-1:0] bitCnt;
    logic [7:0]              digit [8];
    logic                    dinS, clkS, ncsS, clkRise, ncsRise, ncsFall, shiftEn, commit;
    logic [3:0]              frmAddr;
    logic [7:0]              frmData;

    always_comb begin
        dinS    = dinSync[SYNC_STAGES-1];
        clkS    = clkSync[SYNC_STAGES-1];
        ncsS    = ncsSync[SYNC_STAGES-1];
        clkRise = clkS & ~clkPrev;
        ncsRise = ncsS & ~ncsPrev;
        ncsFall = ~ncsS & ncsPrev;
        shiftEn = clkRise & ~ncsS;
        commit  = ncsRise & armed & (bitCnt >= BITCNT_WIDTH'(FRAME_BITS));
        frmAddr = sr[11:8];
        frmData = sr[7:0];
    end

    assign max7219_rx_rdData_OutBUS = digit[max7219_rx_rdAddr_InBUS];

    always_ff @(posedge max7219_rx_CLOCK_50 or negedge max7219_rx_RESET_InLow) begin
        if (!max7219_rx_RESET_InLow) begin
            dinSync <= '0;
            clkSync <= '0;
            ncsSync <= '0;
            clkPrev <= 1'b0;
            ncsPrev <= 1'b0;
        end else begin
            dinSync <= {dinSync[SYNC_STAGES-2:0], max7219_rx_din_In};
            clkSync <= {clkSync[SYNC_STAGES-2:0], max7219_rx_clk_In};
            ncsSync <= {ncsSync[SYNC_STAGES-2:0], max7219_rx_ncs_In};
            clkPrev <= clkS;
            ncsPrev <= ncsS;
        end
    end

    // A window only counts once its falling ncs edge was seen after reset.
    always_ff @(posedge max7219_rx_CLOCK_50 or negedge max7219_rx_RESET_InLow) begin
        if (!max7219_rx_RESET_InLow) begin
            sr     <= '0;
            bitCnt <= '0;
            armed  <= 1'b0;
        end else begin
            if (shiftEn) sr <= {sr[SR_BITS-2:0], dinS};
            if (ncsFall) bitCnt <= shiftEn ? BITCNT_WIDTH'(1) : '0;
            else if (shiftEn && bitCnt != '1) bitCnt <= bitCnt + 1'b1;
            armed <= ncsFall ? 1'b1 : (ncsRise ? 1'b0 : armed);
        end
    end

    always_ff @(posedge max7219_rx_CLOCK_50 or negedge max7219_rx_RESET_InLow) begin
        if (!max7219_rx_RESET_InLow) begin
            for (int i = 0; i < 8; i++) digit[i] <= '0;
            max7219_rx_intensity_OutBUS <= '0;
            max7219_rx_scanLimit_OutBUS <= '0;
            max7219_rx_decode_OutBUS    <= '0;
            max7219_rx_shutdownN_Out    <= 1'b0;
            max7219_rx_test_Out         <= 1'b0;
        end else if (commit) begin
            if (frmAddr inside {[4'h1:4'h8]}) digit[3'(frmAddr - 4'd1)] <= frmData;
            if (frmAddr == 4'h9) max7219_rx_decode_OutBUS <= frmData;
            if (frmAddr == 4'hA) max7219_rx_intensity_OutBUS <= frmData[3:0];
            if (frmAddr == 4'hB) max7219_rx_scanLimit_OutBUS <= frmData[2:0];
            if (frmAddr == 4'hC) max7219_rx_shutdownN_Out <= frmData[0];
            if (frmAddr == 4'hF) max7219_rx_test_Out <= frmData[0];
        end
    end

    always_ff @(posedge max7219_rx_CLOCK_50 or negedge max7219_rx_RESET_InLow) begin
        if (!max7219_rx_RESET_InLow) begin
            max7219_rx_frameValid_Out   <= 1'b0;
            max7219_rx_frameErr_Out     <= 1'b0;
            max7219_rx_frameAddr_OutBUS <= '0;
        end else begin
            max7219_rx_frameValid_Out <= commit;
            max7219_rx_frameErr_Out   <= ncsRise & armed & ~commit;
            if (commit) max7219_rx_frameAddr_OutBUS <= frmAddr;
        end
    end

`ifdef MAX7219_RX_DAISY_EN
    always_ff @(posedge max7219_rx_CLOCK_50 or negedge max7219_rx_RESET_InLow) begin
        if (!max7219_rx_RESET_InLow) max7219_rx_dout_Out <= 1'b0;
        else if (shiftEn) max7219_rx_dout_Out <= sr[SR_BITS-1];
    end
`endif

endmodule

// File: tb/tb_max7219_rx_decoder.sv
// tb_max7219_rx_decoder: table-driven frame vectors plus reset, mid-frame reset and daisy sequences.
module tb_max7219_rx_decoder;

    logic       clk50 = 1'b0, rstN = 1'b0, din = 1'b0, sclk = 1'b0, ncs = 1'b1;
    logic [2:0] rdAddr = 3'd0;
    logic [7:0] rdData, decode;
    logic [3:0] intensity, frameAddr;
    logic [2:0] scanLimit;
    logic       shutdownN, test, frameValid, frameErr;
`ifdef MAX7219_RX_DAISY_EN
    logic       dout;
`endif

    max7219_rx_decoder dut (
        .max7219_rx_CLOCK_50         (clk50),
        .max7219_rx_RESET_InLow      (rstN),
        .max7219_rx_din_In           (din),
        .max7219_rx_clk_In           (sclk),
        .max7219_rx_ncs_In           (ncs),
        .max7219_rx_rdAddr_InBUS     (rdAddr),
        .max7219_rx_rdData_OutBUS    (rdData),
        .max7219_rx_intensity_OutBUS (intensity),
        .max7219_rx_scanLimit_OutBUS (scanLimit),
        .max7219_rx_decode_OutBUS    (decode),
        .max7219_rx_shutdownN_Out    (shutdownN),
        .max7219_rx_test_Out         (test),
        .max7219_rx_frameValid_Out   (frameValid),
        .max7219_rx_frameAddr_OutBUS (frameAddr),
`ifdef MAX7219_RX_DAISY_EN
        .max7219_rx_dout_Out         (dout),
`endif
        .max7219_rx_frameErr_Out     (frameErr)
    );

    always #10 clk50 = ~clk50;

    typedef struct {
        logic [63:0] bits;
        int          nBits;
        logic [2:0]  rd;
        logic [7:0]  rdData;
        logic [3:0]  intensity;
        logic [2:0]  scanLimit;
        logic [7:0]  decode;
        logic        shutdownN;
        logic        test;
        logic [3:0]  frameAddr;
        int          nValid;
        int          nErr;
    } vec_t;

    vec_t        vecs [17];
    int          nVec = 0, nBad = 0;
    int          validCnt = 0, errCnt = 0;
    int          lat;
    logic [15:0] doutCap = '0;
    logic [7:0]  rowExp [8];

    // Pulse widths are measured by counting high cycles, so a stretched pulse shows up as >1.
    always @(negedge clk50) begin
        if (frameValid) validCnt++;
        if (frameErr) errCnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk50);
            #1;
        end
    endtask

    task automatic sendBits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            din = v[i];
            tick(4);
            sclk = 1'b1;
            tick(4);
`ifdef MAX7219_RX_DAISY_EN
            doutCap = {doutCap[14:0], dout};
`endif
            sclk = 1'b0;
        end
    endtask

    // lat = CLOCK_50 edges from the ncs pin rise to the visible pulse; 0 means none within the bound.
    task automatic sendFrame(input logic [63:0] v, input int n, output int l);
        ncs = 1'b0;
        tick(4);
        sendBits(v, n);
        tick(4);
        ncs = 1'b1;
        l = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (l == 0 && (frameValid || frameErr)) l = k;
        end
        tick(2);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [7:0] rd, input logic [3:0] inten, input logic [2:0] sl,
                                         input logic [7:0] dec, input logic sh, input logic tst,
                                         input logic [3:0] fa, input int nv, input int ne, input int l);
        return {23'd0, rd, inten, sl, dec, sh, tst, fa, 4'(nv), 4'(ne), 4'(l)};
    endfunction

    initial begin
        vecs[0]  = '{64'h0C01, 16, 3'd0, 8'h00, 4'h0, 3'd0, 8'h00, 1'b1, 1'b0, 4'hC, 1, 0};
        vecs[1]  = '{64'h0355, 16, 3'd2, 8'h55, 4'h0, 3'd0, 8'h00, 1'b1, 1'b0, 4'h3, 1, 0};
        vecs[2]  = '{64'h00A7, 12, 3'd2, 8'h55, 4'h0, 3'd0, 8'h00, 1'b1, 1'b0, 4'h3, 0, 1};
        vecs[3]  = '{64'hAB0A07, 24, 3'd2, 8'h55, 4'h7, 3'd0, 8'h00, 1'b1, 1'b0, 4'hA, 1, 0};
        vecs[4]  = '{64'h0B05, 16, 3'd3, 8'h00, 4'h7, 3'd5, 8'h00, 1'b1, 1'b0, 4'hB, 1, 0};
        vecs[5]  = '{64'h09FF, 16, 3'd3, 8'h00, 4'h7, 3'd5, 8'hFF, 1'b1, 1'b0, 4'h9, 1, 0};
        vecs[6]  = '{64'h0F01, 16, 3'd2, 8'h55, 4'h7, 3'd5, 8'hFF, 1'b1, 1'b1, 4'hF, 1, 0};
        vecs[7]  = '{64'h0000, 16, 3'd2, 8'h55, 4'h7, 3'd5, 8'hFF, 1'b1, 1'b1, 4'h0, 1, 0};
        vecs[8]  = '{64'h0D33, 16, 3'd2, 8'h55, 4'h7, 3'd5, 8'hFF, 1'b1, 1'b1, 4'hD, 1, 0};
        vecs[9]  = '{64'hF1AA, 16, 3'd0, 8'hAA, 4'h7, 3'd5, 8'hFF, 1'b1, 1'b1, 4'h1, 1, 0};
        vecs[10] = '{64'h0C00, 16, 3'd0, 8'hAA, 4'h7, 3'd5, 8'hFF, 1'b0, 1'b1, 4'hC, 1, 0};
        vecs[11] = '{64'h0A1F, 16, 3'd0, 8'hAA, 4'hF, 3'd5, 8'hFF, 1'b0, 1'b1, 4'hA, 1, 0};
        vecs[12] = '{64'h0B0F, 16, 3'd0, 8'hAA, 4'hF, 3'd7, 8'hFF, 1'b0, 1'b1, 4'hB, 1, 0};
        vecs[13] = '{64'h12_3456_0207, 40, 3'd1, 8'h07, 4'hF, 3'd7, 8'hFF, 1'b0, 1'b1, 4'h2, 1, 0};
        vecs[14] = '{64'h0, 0, 3'd1, 8'h07, 4'hF, 3'd7, 8'hFF, 1'b0, 1'b1, 4'h2, 0, 1};
        vecs[15] = '{64'h0F00, 16, 3'd7, 8'h00, 4'hF, 3'd7, 8'hFF, 1'b0, 1'b0, 4'hF, 1, 0};
        vecs[16] = '{64'h1234, 15, 3'd1, 8'h07, 4'hF, 3'd7, 8'hFF, 1'b0, 1'b0, 4'hF, 0, 1};
        rowExp = '{8'hAA, 8'h07, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        tick(3);
        rstN = 1'b1;
        tick(8);
        for (int r = 0; r < 8; r++) begin
            rdAddr = 3'(r);
            #1;
            check($sformatf("reset row%0d", r), 64'(rdData), 64'h0);
        end
        check("reset regs", pack(8'h00, intensity, scanLimit, decode, shutdownN, test, frameAddr, validCnt, errCnt, 0),
              pack(8'h00, 4'h0, 3'd0, 8'h00, 1'b0, 1'b0, 4'h0, 0, 0, 0));

        // Every committed or rejected frame pulses SYNC_STAGES+1 edges after the ncs pin rise.
        for (int v = 0; v < 17; v++) begin
            validCnt = 0;
            errCnt = 0;
            rdAddr = vecs[v].rd;
            sendFrame(vecs[v].bits, vecs[v].nBits, lat);
            check($sformatf("vec%0d", v),
                  pack(rdData, intensity, scanLimit, decode, shutdownN, test, frameAddr, validCnt, errCnt, lat),
                  pack(vecs[v].rdData, vecs[v].intensity, vecs[v].scanLimit, vecs[v].decode, vecs[v].shutdownN,
                       vecs[v].test, vecs[v].frameAddr, vecs[v].nValid, vecs[v].nErr, 3));
        end

        for (int r = 0; r < 8; r++) begin
            rdAddr = 3'(r);
            #1;
            check($sformatf("sweep row%0d", r), 64'(rdData), 64'(rowExp[r]));
        end

        // Reset in the middle of a frame: remainder must neither commit nor flag an error.
        validCnt = 0;
        errCnt = 0;
        rdAddr = 3'd7;
        ncs = 1'b0;
        tick(4);
        sendBits(64'h08, 8);
        rstN = 1'b0;
        tick(2);
        rstN = 1'b1;
        tick(4);
        sendBits(64'hFF, 8);
        tick(4);
        ncs = 1'b1;
        tick(12);
        check("midreset no commit", pack(rdData, intensity, scanLimit, decode, shutdownN, test, frameAddr, validCnt, errCnt, 0),
              pack(8'h00, 4'h0, 3'd0, 8'h00, 1'b0, 1'b0, 4'h0, 0, 0, 0));
        validCnt = 0;
        errCnt = 0;
        sendFrame(64'h0801, 16, lat);
        check("post-reset digit7", pack(rdData, intensity, scanLimit, decode, shutdownN, test, frameAddr, validCnt, errCnt, lat),
              pack(8'h01, 4'h0, 3'd0, 8'h00, 1'b0, 1'b0, 4'h8, 1, 0, 3));

`ifdef MAX7219_RX_DAISY_EN
        sendFrame(64'h0A05, 16, lat);
        sendFrame(64'h0102, 16, lat);
        check("daisy dout", 64'(doutCap), 64'h0A05);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
